// File: rtl/stage_memory.sv
// MEM pipeline stage: word loads/stores over a req/ack data port, result
// select into the MEM/WB register, misalignment capture and stall counting.
module stage_memory #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_clear,
  input  logic                   mem_reg_write,
  input  logic                   mem_mem_write,
  input  logic [1:0]             mem_result_src,
  input  logic [31:0]            mem_alu_result,
  input  logic [31:0]            mem_write_data,
  input  logic [31:0]            mem_pc_plus_4,
  input  logic [31:0]            mem_imm_ext,
  input  logic [4:0]             mem_rd,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [31:0]            dmem_addr,
  output logic [31:0]            dmem_wdata,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_ack,
  output logic                   mem_stall,
  output logic                   wb_reg_write,
  output logic [4:0]             wb_rd,
  output logic [31:0]            wb_result,
  output logic                   misalign_err,
  output logic [31:0]            misalign_addr,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // state | meaning
  // IDLE  | no outstanding request; launch aligned memory ops
  // WAIT  | request outstanding, holding dmem_* until dmem_ack
  typedef enum logic {IDLE, WAIT} state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   wb_we_q, wb_we_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic [31:0]            wb_res_q, wb_res_d;
  logic                   err_q, err_d;
  logic [31:0]            err_addr_q, err_addr_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic        mem_op, aligned, launch, misal, stall;
  logic [31:0] result;

  assign mem_op  = mem_mem_write | (mem_result_src == 2'b01);
  assign aligned = (mem_alu_result[1:0] == 2'b00);
  assign launch  = (state_q == IDLE) & mem_op & aligned;
  assign misal   = (state_q == IDLE) & mem_op & ~aligned;
  // Gated by reset so the hazard unit never sees a stall during reset.
  assign stall   = reset & (launch | ((state_q == WAIT) & ~dmem_ack));

  always_comb begin
    result = mem_alu_result;
    unique case (mem_result_src)
      2'b00:   result = mem_alu_result;
      2'b01:   result = dmem_rdata;
      2'b10:   result = mem_pc_plus_4;
      default: result = mem_imm_ext;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    stall_d    = stall ? stall_q + STALL_CNT_W'(1) : stall_q;

    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = mem_mem_write;
          addr_d  = mem_alu_result;
          wdata_d = mem_write_data;
        end
        if (misal && !err_q) begin
          err_d      = 1'b1;
          err_addr_d = mem_alu_result;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_we_d  = 1'b0;
    wb_rd_d  = 5'd0;
    wb_res_d = 32'd0;
    if (!wb_clear && !stall) begin
      wb_we_d  = mem_reg_write & ~misal;
      wb_rd_d  = mem_rd;
      wb_res_d = result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_res_q   <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_res_q   <= wb_res_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      stall_q    <= stall_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign mem_stall     = stall;
  assign wb_reg_write  = wb_we_q;
  assign wb_rd         = wb_rd_q;
  assign wb_result     = wb_res_q;
  assign misalign_err  = err_q;
  assign misalign_addr = err_addr_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed table, reset-in-WAIT
// sequence and randomized instructions against a transaction-level model.
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_clear = 1'b0;
  logic        mem_reg_write = 1'b0, mem_mem_write = 1'b0;
  logic [1:0]  mem_result_src = 2'b00;
  logic [31:0] mem_alu_result = '0, mem_write_data = '0, mem_pc_plus_4 = '0, mem_imm_ext = '0;
  logic [4:0]  mem_rd = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        mem_stall, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        misalign_err;
  logic [31:0] misalign_addr;
  logic [31:0] stall_cycles;

  stage_memory #(.STALL_CNT_W(32)) dut (
    .clk(clk), .reset(reset), .wb_clear(wb_clear),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_pc_plus_4(mem_pc_plus_4),
    .mem_imm_ext(mem_imm_ext), .mem_rd(mem_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .misalign_err(misalign_err),
    .misalign_addr(misalign_addr), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mw;
    logic [1:0]  src;
    logic [31:0] alu, wd, pc4, imm;
    logic [4:0]  rd;
    int          delay;
    logic [31:0] rdata;
    logic        clr, ack_idle;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_res;
    logic        chk_res;
  } vec_t;

  int n_tests = 0, n_fail = 0;
  // Transaction-level model state
  int unsigned m_stalls = 0;
  logic        m_err = 1'b0;
  logic [31:0] m_err_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic rw, mw, input logic [1:0] src,
                               input logic [31:0] alu, wd, pc4, imm, input logic [4:0] rd,
                               input int delay, input logic [31:0] rdata, input logic clr, ack_idle,
                               input logic exp_we, input logic [4:0] exp_rd,
                               input logic [31:0] exp_res, input logic chk_res);
    vec_t v;
    v.rw = rw; v.mw = mw; v.src = src; v.alu = alu; v.wd = wd; v.pc4 = pc4;
    v.imm = imm; v.rd = rd; v.delay = delay; v.rdata = rdata; v.clr = clr;
    v.ack_idle = ack_idle; v.exp_we = exp_we; v.exp_rd = exp_rd;
    v.exp_res = exp_res; v.chk_res = chk_res;
    return v;
  endfunction

  // Expected write-back derived from the stage's rules, not its structure.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic is_mem = v.mw | (v.src == 2'b01);
    logic bad    = is_mem & (v.alu % 4 != 0);
    r.chk_res = 1'b1;
    if (v.clr) begin
      r.exp_we = 0; r.exp_rd = 0; r.exp_res = 0;
    end else begin
      r.exp_we = v.rw & ~bad;
      r.exp_rd = v.rd;
      case (v.src)
        2'b00: r.exp_res = v.alu;
        2'b01: begin r.exp_res = v.rdata; r.chk_res = ~bad; end
        2'b10: r.exp_res = v.pc4;
        default: r.exp_res = v.imm;
      endcase
    end
    return r;
  endfunction

  // Called and returns at posedge+1.
  task automatic run(input vec_t v);
    logic is_mem = v.mw | (v.src == 2'b01);
    logic ok     = (v.alu % 4 == 0);
    mem_reg_write = v.rw; mem_mem_write = v.mw; mem_result_src = v.src;
    mem_alu_result = v.alu; mem_write_data = v.wd; mem_pc_plus_4 = v.pc4;
    mem_imm_ext = v.imm; mem_rd = v.rd; wb_clear = v.clr;
    if (is_mem && ok) begin
      dmem_ack = 1'b0;
      #4 chk("stall_launch", {31'd0, mem_stall}, 32'd1);
      @(posedge clk); #1;
      for (int k = 0; k <= v.delay; k++) begin
        chk("req_held", {31'd0, dmem_req}, 32'd1);
        chk("addr", dmem_addr, v.alu);
        chk("we", {31'd0, dmem_we}, {31'd0, v.mw});
        if (v.mw) chk("wdata", dmem_wdata, v.wd);
        chk("bubble_we", {31'd0, wb_reg_write}, 32'd0);
        chk("bubble_rd", {27'd0, wb_rd}, 32'd0);
        dmem_ack   = (k == v.delay);
        dmem_rdata = (k == v.delay) ? v.rdata : $urandom();
        #4 chk("stall_wait", {31'd0, mem_stall}, {31'd0, (k != v.delay)});
        @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
      m_stalls += v.delay + 1;
    end else begin
      if (is_mem && !m_err) begin m_err = 1'b1; m_err_addr = v.alu; end
      dmem_ack = v.ack_idle;
      dmem_rdata = $urandom();
      #4 chk("no_stall", {31'd0, mem_stall}, 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    wb_clear = 1'b0;
    chk("wb_we", {31'd0, wb_reg_write}, {31'd0, v.exp_we});
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, v.exp_rd});
    if (v.chk_res) chk("wb_result", wb_result, v.exp_res);
    chk("req_idle", {31'd0, dmem_req}, 32'd0);
    chk("stall_cycles", stall_cycles, m_stalls);
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
    chk("misalign_addr", misalign_addr, m_err_addr);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
    chk({tag, "_wbwe"}, {31'd0, wb_reg_write}, 32'd0);
    chk({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
    chk({tag, "_wbres"}, wb_result, 32'd0);
    chk({tag, "_err"}, {31'd0, misalign_err}, 32'd0);
    chk({tag, "_erraddr"}, misalign_addr, 32'd0);
    chk({tag, "_stalls"}, stall_cycles, 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    //        rw mw src   alu           wd            pc4      imm           rd dly rdata         clr ai  ewe erd exp_res       chk
    tbl.push_back(mkv(1, 0, 2'b00, 32'h12,       0,            0,       0,            5, 0, 0,            0, 0,  1,  5, 32'h12,       1));
    tbl.push_back(mkv(1, 0, 2'b01, 32'h100,      0,            0,       0,            7, 2, 32'hDEADBEEF, 0, 0,  1,  7, 32'hDEADBEEF, 1));
    tbl.push_back(mkv(0, 1, 2'b00, 32'h40,       32'hCAFEF00D, 0,       0,            0, 0, 0,            0, 0,  0,  0, 32'h40,       1));
    tbl.push_back(mkv(1, 0, 2'b01, 32'h40,       0,            0,       0,            9, 0, 32'hCAFEF00D, 0, 0,  1,  9, 32'hCAFEF00D, 1));
    tbl.push_back(mkv(0, 1, 2'b00, 32'h43,       32'h1,        0,       0,            0, 0, 0,            0, 0,  0,  0, 32'h43,       1));
    tbl.push_back(mkv(1, 0, 2'b01, 32'h81,       0,            0,       0,            3, 0, 0,            0, 0,  0,  3, 0,            0));
    tbl.push_back(mkv(1, 0, 2'b10, 32'h7,        0,            32'h204, 0,            1, 0, 0,            0, 1,  1,  1, 32'h204,      1));
    tbl.push_back(mkv(1, 0, 2'b11, 32'h0,        0,            0,       32'hFFFFF800, 2, 0, 0,            0, 0,  1,  2, 32'hFFFFF800, 1));
    tbl.push_back(mkv(1, 0, 2'b01, 32'h200,      0,            0,       0,            4, 2, 32'h11111111, 1, 0,  0,  0, 0,            1));
    tbl.push_back(mkv(1, 0, 2'b00, 32'h55,       0,            0,       0,            6, 0, 0,            1, 0,  0,  0, 0,            1));
    tbl.push_back(mkv(1, 1, 2'b00, 32'h2,        32'h9,        0,       0,            8, 0, 0,            0, 0,  0,  8, 32'h2,        1));
    tbl.push_back(mkv(1, 0, 2'b00, 32'h99,       0,            0,       0,            10, 0, 0,           0, 0,  1, 10, 32'h99,       1));

    #2 check_all_zero("rst_init");
    @(posedge clk); #1 reset = 1'b1;

    foreach (tbl[i]) run(tbl[i]);

    // Reset asserted asynchronously while a load is outstanding.
    mem_reg_write = 1; mem_mem_write = 0; mem_result_src = 2'b01;
    mem_alu_result = 32'h300; mem_rd = 5'd11; dmem_ack = 0;
    @(posedge clk); #1;
    chk("rst_pre_req", {31'd0, dmem_req}, 32'd1);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_wait");
    mem_reg_write = 0; mem_result_src = 2'b00; mem_alu_result = 0; mem_rd = 0;
    @(negedge clk) reset = 1'b1;
    m_stalls = 0; m_err = 1'b0; m_err_addr = '0;
    @(posedge clk); #1;
    run(mkv(1, 0, 2'b00, 32'h12, 0, 0, 0, 5, 0, 0, 0, 0, 1, 5, 32'h12, 1));

    for (int n = 0; n < 60; n++) begin
      vec_t v;
      v.rw = $urandom_range(0, 1); v.mw = $urandom_range(0, 1);
      v.src = 2'($urandom_range(0, 3));
      v.alu = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) v.alu = v.alu | 32'($urandom_range(1, 3));
      v.wd = $urandom(); v.pc4 = $urandom(); v.imm = $urandom();
      v.rd = 5'($urandom_range(0, 31)); v.delay = $urandom_range(0, 3);
      v.rdata = $urandom(); v.clr = ($urandom_range(0, 7) == 0);
      v.ack_idle = $urandom_range(0, 1);
      run(model(v));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
